// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - AXI-Stream width upsizer packing RATIO narrow beats into one wide beat
module axis_upsizer #(
    parameter int WIDTH_P = 32,
    parameter int WIDTH_S = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cfg,
    input  logic [WIDTH_P-1:0]           p_axis_data,
    input  logic                         p_axis_valid,
    input  logic                         p_axis_last,
    output logic                         p_axis_ready,
    output logic [WIDTH_S-1:0]           s_axis_data,
    output logic [WIDTH_S/WIDTH_P-1:0]   s_axis_keep,
    output logic                         s_axis_valid,
    output logic                         s_axis_last,
    input  logic                         s_axis_ready
);

    localparam int RATIO = WIDTH_S / WIDTH_P;
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    // Reject geometries that cannot be packed lane-for-lane.
    generate
        if (RATIO < 2 || (WIDTH_S % WIDTH_P) != 0) begin : g_bad_ratio
            $error("axis_upsizer: WIDTH_S must be an integer multiple (>=2) of WIDTH_P");
        end
    endgenerate

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cfg_q, cfg_d;
    logic [WIDTH_S-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]   acc_keep_q, acc_keep_d;
    logic [WIDTH_S-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]   out_keep_q, out_keep_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;

    logic               accept;
    logic               complete;
    logic [1:0]         eff_cfg;
    logic [CNT_W-1:0]   lane;
    logic [WIDTH_S-1:0] merged_data;
    logic [RATIO-1:0]   merged_keep;
    logic [WIDTH_S-1:0] padded_data;

    // Ready only looks at the output register, never at the input side; held low in reset.
    assign p_axis_ready = rst && (!out_valid_q || s_axis_ready);

    assign s_axis_data  = out_data_q;
    assign s_axis_keep  = out_keep_q;
    assign s_axis_valid = out_valid_q;
    assign s_axis_last  = out_last_q;

    // Lane selection, merge of the incoming beat and padding of unfilled lanes.
    always_comb begin
        accept      = p_axis_valid && p_axis_ready;
        // The first beat of a word uses live cfg; later beats use the copy latched with it.
        eff_cfg     = (cnt_q == '0) ? cfg : cfg_q;
        lane        = eff_cfg[0] ? (CNT_W'(RATIO - 1) - cnt_q) : cnt_q;
        complete    = accept && ((cnt_q == CNT_W'(RATIO - 1)) || p_axis_last);
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane == CNT_W'(k)) begin
                merged_data[k*WIDTH_P +: WIDTH_P] = p_axis_data;
                merged_keep[k]                    = 1'b1;
            end
        end
        padded_data = merged_data;
        for (int k = 0; k < RATIO; k++) begin
            if (!merged_keep[k]) begin
                padded_data[k*WIDTH_P +: WIDTH_P] = {WIDTH_P{eff_cfg[1]}};
            end
        end
    end

    // Next-state for the accumulator and the output register.
    always_comb begin
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (accept) begin
            cfg_d = eff_cfg;
            if (complete) begin
                cnt_d      = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
            end else begin
                cnt_d      = cnt_q + CNT_W'(1);
                acc_data_d = merged_data;
                acc_keep_d = merged_keep;
            end
        end

        // A completing beat can only be accepted when the output is empty or draining,
        // so reloading here never overwrites an untransferred word.
        if (complete) begin
            out_data_d  = padded_data;
            out_keep_d  = merged_keep;
            out_last_d  = p_axis_last;
            out_valid_d = 1'b1;
        end else if (s_axis_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any partial word and any pending output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            cfg_q       <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - self-checking bench for axis_upsizer
module tb_axis_upsizer;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg;
    logic [31:0] p_axis_data;
    logic        p_axis_valid;
    logic        p_axis_last;
    logic        p_axis_ready;
    logic [63:0] s_axis_data;
    logic [1:0]  s_axis_keep;
    logic        s_axis_valid;
    logic        s_axis_last;
    logic        s_axis_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [66:0] exp_q[$];
    bit          use_model = 0;
    bit          rand_done = 0;

    int          m_cnt = 0;
    logic [1:0]  m_cfg = 2'b00;
    logic [31:0] m_lane0 = '0;
    logic [31:0] m_lane1 = '0;

    axis_upsizer #(.WIDTH_P(32), .WIDTH_S(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg),
        .p_axis_data  (p_axis_data),
        .p_axis_valid (p_axis_valid),
        .p_axis_last  (p_axis_last),
        .p_axis_ready (p_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: reference model for random traffic, scoreboard pop on output transfer.
    always @(negedge clk) begin
        logic [66:0] got;
        logic [66:0] e;
        logic [1:0]  kp;
        logic [31:0] pad;
        int          ln;
        if (!rst) begin
            m_cnt = 0;
        end else begin
            if (use_model && p_axis_valid && p_axis_ready) begin
                if (m_cnt == 0) m_cfg = cfg;
                ln = m_cfg[0] ? (1 - m_cnt) : m_cnt;
                if (ln == 0) m_lane0 = p_axis_data; else m_lane1 = p_axis_data;
                if (m_cnt == 1 || p_axis_last) begin
                    if (m_cnt == 1) kp = 2'b11;
                    else kp = (ln == 0) ? 2'b01 : 2'b10;
                    pad = m_cfg[1] ? 32'hFFFF_FFFF : 32'h0;
                    exp_q.push_back({p_axis_last, kp, kp[1] ? m_lane1 : pad, kp[0] ? m_lane0 : pad});
                    m_cnt = 0;
                end else begin
                    m_cnt = 1;
                end
            end
            if (s_axis_valid && s_axis_ready) begin
                got = {s_axis_last, s_axis_keep, s_axis_data};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected got last/keep/data=%h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL out_word got last/keep/data=%h expected %h", got, e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] c);
        bit ok;
        ok = 0;
        p_axis_valid = 1'b1;
        p_axis_data  = d;
        p_axis_last  = l;
        cfg          = c;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (p_axis_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout got ready=0 expected accept of %h", d);
        end
        @(posedge clk);
        #1;
        p_axis_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, p_axis_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%h k=%b l=%b r=%b expected all 0",
                     s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, p_axis_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (p_axis_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got %b expected 1", p_axis_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned;
        s_axis_ready = 1'b1;
        exp_q.push_back({1'b0, 2'b11, 64'h2222_2222_1111_1111});
        exp_q.push_back({1'b1, 2'b11, 64'h4444_4444_3333_3333});
        send(32'h1111_1111, 1'b0, 2'b00);
        n_cmp++;
        if (s_axis_valid !== 1'b0) begin
            n_err++;
            $display("FAIL aligned_early_valid got %b expected 0", s_axis_valid);
        end
        send(32'h2222_2222, 1'b0, 2'b00);
        n_cmp++;
        if (s_axis_valid !== 1'b1 || p_axis_ready !== 1'b1) begin
            n_err++;
            $display("FAIL aligned_latency got valid=%b ready=%b expected 1 1", s_axis_valid, p_axis_ready);
        end
        send(32'h3333_3333, 1'b0, 2'b00);
        send(32'h4444_4444, 1'b1, 2'b00);
        n_cmp++;
        if (s_axis_valid !== 1'b1 || p_axis_ready !== 1'b1) begin
            n_err++;
            $display("FAIL aligned_latency2 got valid=%b ready=%b expected 1 1", s_axis_valid, p_axis_ready);
        end
        idle(3);
        check_drained("aligned");
    endtask

    task automatic test_odd_pad;
        exp_q.push_back({1'b0, 2'b11, 64'hBBBB_BBBB_AAAA_AAAA});
        exp_q.push_back({1'b1, 2'b01, 64'hFFFF_FFFF_CCCC_CCCC});
        send(32'hAAAA_AAAA, 1'b0, 2'b10);
        send(32'hBBBB_BBBB, 1'b0, 2'b10);
        send(32'hCCCC_CCCC, 1'b1, 2'b10);
        idle(3);
        check_drained("odd_pad");
    endtask

    task automatic test_lane_swap;
        exp_q.push_back({1'b1, 2'b11, 64'h0000_0001_0000_0002});
        exp_q.push_back({1'b1, 2'b10, 64'h0000_0009_0000_0000});
        send(32'h0000_0001, 1'b0, 2'b01);
        send(32'h0000_0002, 1'b1, 2'b01);
        send(32'h0000_0009, 1'b1, 2'b01);
        idle(3);
        check_drained("lane_swap");
    endtask

    task automatic test_cfg_change;
        exp_q.push_back({1'b0, 2'b11, 64'h0000_0006_0000_0005});
        exp_q.push_back({1'b1, 2'b11, 64'h0000_0007_0000_0008});
        send(32'h0000_0005, 1'b0, 2'b00);
        send(32'h0000_0006, 1'b0, 2'b01);
        send(32'h0000_0007, 1'b0, 2'b01);
        send(32'h0000_0008, 1'b1, 2'b00);
        idle(3);
        check_drained("cfg_change");
    endtask

    task automatic test_reset_mid_word;
        send(32'hDEAD_0001, 1'b0, 2'b10);
        rst          = 1'b0;
        p_axis_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, p_axis_ready} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got v=%b d=%h k=%b l=%b r=%b expected all 0",
                     s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, p_axis_ready);
        end
        @(posedge clk);
        #1;
        rst          = 1'b1;
        p_axis_valid = 1'b0;
        exp_q.push_back({1'b1, 2'b11, 64'h0000_0002_0000_0001});
        send(32'h0000_0001, 1'b0, 2'b00);
        send(32'h0000_0002, 1'b1, 2'b00);
        idle(3);
        check_drained("midreset");
    endtask

    task automatic test_backpressure;
        s_axis_ready = 1'b0;
        exp_q.push_back({1'b0, 2'b11, 64'h0506_0708_0102_0304});
        exp_q.push_back({1'b1, 2'b01, 64'h0000_0000_0A0B_0C0D});
        send(32'h0102_0304, 1'b0, 2'b00);
        send(32'h0506_0708, 1'b0, 2'b00);
        p_axis_valid = 1'b1;
        p_axis_data  = 32'h0A0B_0C0D;
        p_axis_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (p_axis_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready cycle %0d got %b expected 0", i, p_axis_ready);
            end
            n_cmp++;
            if ({s_axis_valid, s_axis_last, s_axis_keep, s_axis_data} !== {1'b1, 1'b0, 2'b11, 64'h0506_0708_0102_0304}) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got v=%b l=%b k=%b d=%h expected 1 0 11 0506070801020304",
                         i, s_axis_valid, s_axis_last, s_axis_keep, s_axis_data);
            end
            @(posedge clk);
            #1;
        end
        s_axis_ready = 1'b1;
        send(32'h0A0B_0C0D, 1'b1, 2'b00);
    endtask

    task automatic test_random_stream;
        use_model = 1;
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    send($urandom, (i == 31) ? 1'b1 : ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    s_axis_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                s_axis_ready = 1'b1;
            end
        join
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
        idle(2);
        check_drained("random");
        use_model = 0;
    endtask

    initial begin
        rst          = 1'b0;
        cfg          = 2'b00;
        p_axis_data  = '0;
        p_axis_valid = 1'b0;
        p_axis_last  = 1'b0;
        s_axis_ready = 1'b1;
        test_reset;
        test_aligned;
        test_odd_pad;
        test_lane_swap;
        test_cfg_change;
        test_reset_mid_word;
        test_backpressure;
        test_random_stream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
